uart_tx_serializer: RTL and testbench

//  Serial transmit back end for the UART: buffers bytes from the AXI-lite UART write slave and shifts them out on o_txd as 8N1 frames.

---
 rtl/uart_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit back end: byte FIFO feeding an 8N1 serializer with a fixed baud divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [7:0]                    i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DIVISOR);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud;
    logic          baud_done;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_tx_ready = !full;
    assign push       = i_tx_valid && !full;
    assign baud_done  = (baud == '0);
    assign pop        = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
    assign head       = mem[rd_ptr[AW-1:0]];

    assign o_fifo_count = wr_ptr - rd_ptr;
    assign o_busy       = (state != IDLE) || !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_tx_data;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            o_txd   <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_txd <= 1'b1;
                    if (pop) begin
                        shift <= head;
`ifdef UART_TX_PARITY_EN
                        parity <= ^head;
`endif
                        o_txd <= 1'b0;
                        baud  <= BAUD_LAST;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        o_txd   <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        baud    <= BAUD_LAST;
                        state   <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (!baud_done) begin
                        baud <= baud - 1'b1;
                    end else if (bit_cnt == 3'd7) begin
                        baud <= BAUD_LAST;
`ifdef UART_TX_PARITY_EN
                        o_txd <= parity;
                        state <= PARITY;
`else
                        o_txd <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        o_txd   <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        baud    <= BAUD_LAST;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        o_txd <= 1'b1;
                        baud  <= BAUD_LAST;
                        state <= STOP;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (!baud_done) begin
                        baud <= baud - 1'b1;
                    end else if (pop) begin
                        // Next frame starts immediately: no idle bit between stop and start.
                        shift <= head;
`ifdef UART_TX_PARITY_EN
                        parity <= ^head;
`endif
                        o_txd <= 1'b0;
                        baud  <= BAUD_LAST;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer at DIVISOR=4, FIFO_DEPTH=4.
module tb_uart_tx_serializer;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    uart_tx_serializer #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_txd        (txd),
        .o_busy       (busy),
        .o_fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Expected line level k cycles into a frame (k=0 is the cycle after the start bit falls).
    function automatic logic bit_at(input logic [7:0] b, input int k);
        int slot;
        slot = k / DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Advance to the falling edge that follows posedge number 'target'.
    task automatic step_to(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %0b want 1", txd); end
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", tx_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
                n_fail++;
                $display("FAIL idle_line cycle %0d: txd=%0b busy=%0b count=%0d want 1/0/0", i, txd, busy, fifo_count);
            end
        end
    endtask

    // Push one byte into an idle, empty block and check the whole frame cycle by cycle.
    task automatic send_and_check(input logic [7:0] b, input string name);
        int base;
        base     = edge_cnt + 1;
        tx_valid = 1'b1;
        tx_data  = b;
        step_to(base);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        n_checks++;
        if (txd !== 1'b1 || fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL %s_latency: txd=%0b count=%0d want 1/1", name, txd, fifo_count);
        end
        for (int k = 0; k < FRAME; k++) begin
            step_to(base + 1 + k);
            n_checks++;
            if (txd !== bit_at(b, k)) begin
                n_fail++;
                $display("FAIL %s_bit cycle %0d: txd=%0b want %0b", name, k + 1, txd, bit_at(b, k));
            end
        end
        step_to(base + FRAME);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_last: got %0b want 1", name, busy); end
        step_to(base + FRAME + 1);
        n_checks++;
        if (busy !== 1'b0 || txd !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_end: busy=%0b txd=%0b count=%0d want 0/1/0", name, busy, txd, fifo_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        send_and_check(8'h55, "single_55");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_and_check(8'h07, "parity_07");
        send_and_check(8'h03, "parity_03");
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        int acc [6];
        int acc_exp [6];
        int base;
        bytes   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        acc_exp = '{0, 1, 2, 3, 4, 42};
        acc     = '{-1, -1, -1, -1, -1, -1};
        do_reset();
        base = edge_cnt + 1;
        fork
            begin : driver
                int idx;
                int guard;
                idx      = 0;
                guard    = 0;
                tx_valid = 1'b1;
                tx_data  = bytes[0];
                while (idx < 6 && guard < 400) begin
                    if (tx_ready) begin
                        acc[idx] = edge_cnt + 1 - base;
                        idx++;
                    end
                    @(negedge clk);
                    guard++;
                    if (idx < 6) tx_data = bytes[idx];
                    else tx_valid = 1'b0;
                end
                tx_valid = 1'b0;
            end
            begin : monitor
                int rel;
                for (int k = 0; k < 6 * FRAME; k++) begin
                    rel = 1 + k;
                    step_to(base + rel);
                    n_checks++;
                    if (txd !== bit_at(bytes[k / FRAME], k % FRAME)) begin
                        n_fail++;
                        $display("FAIL b2b_bit cycle %0d: txd=%0b want %0b", rel, txd, bit_at(bytes[k / FRAME], k % FRAME));
                    end
                    if (rel == 4) begin
                        n_checks++;
                        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %0b want 0", tx_ready); end
                    end
                    if (rel == 40) begin
                        n_checks++;
                        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_pop_count_40: got %0d want 4", fifo_count); end
                    end
                    if (rel == 41) begin
                        n_checks++;
                        if (fifo_count !== 3'd3 || tx_ready !== 1'b1) begin
                            n_fail++;
                            $display("FAIL full_pop_count_41: count=%0d ready=%0b want 3/1", fifo_count, tx_ready);
                        end
                    end
                    if (rel == 42) begin
                        n_checks++;
                        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_pop_count_42: got %0d want 4", fifo_count); end
                    end
                end
            end
        join
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (acc[i] !== acc_exp[i]) begin
                n_fail++;
                $display("FAIL b2b_accept byte %0d: edge %0d want %0d", i + 1, acc[i], acc_exp[i]);
            end
        end
        step_to(base + 6 * FRAME);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_last: got %0b want 1", busy); end
        step_to(base + 6 * FRAME + 1);
        n_checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: busy=%0b txd=%0b want 0/1", busy, txd);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        do_reset();
        base     = edge_cnt + 1;
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        step_to(base);
        tx_data = 8'h11;
        step_to(base + 1);
        tx_data = 8'h22;
        step_to(base + 2);
        tx_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL midrst_queued: got %0d want 2", fifo_count); end
        // Cycle 14 carries data bit 2 of 0xA3, which is a zero.
        step_to(base + 14);
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_bit: got %0b want 0", txd); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (txd !== 1'b1 || fifo_count !== 3'd0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: txd=%0b count=%0d ready=%0b busy=%0b want 1/0/1/0", txd, fifo_count, tx_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if (txd !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after cycle %0d: txd=%0b busy=%0b want 1/0", i, txd, busy);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
